// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: sequencer for an LCD init/refresh engine.
//
// After start, issues INIT_STEPS init commands (mode=0, lcd_cnt=step),
// each one waiting for the engine's lcd_finish pulse. It then issues
// periodic refresh commands (mode=1, lcd_cnt=row 0..3, wrapping) spaced
// by REFRESH_PERIOD cycles. A command not finished within TIMEOUT wait
// cycles drops the controller into FAULT with err set. start re-launches
// the init sequence from IDLE or FAULT.
//
// Parameters:
//   INIT_STEPS      number of init commands (1..4)
//   REFRESH_PERIOD  cycles between refresh commands (>= 2)
//   TIMEOUT         max wait cycles for lcd_finish (>= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       launch init sequence (honoured in IDLE / FAULT only)
//   lcd_finish  one-cycle completion pulse from the engine
//   force_ref   (LCD_SEQ_FORCE_REFRESH_EN only) refresh now while in REF_TMR
//   lcd_enable  one-cycle command strobe
//   mode        0 = init command, 1 = refresh command
//   lcd_cnt     init step / refresh row of the current command
//   busy        command outstanding (issue or wait)
//   init_done   all init steps completed
//   err         sticky timeout flag
//
// Build option: define LCD_SEQ_FORCE_REFRESH_EN to add the force_ref input.

module lcd_seq_ctrl #(
    parameter int INIT_STEPS     = 4,
    parameter int REFRESH_PERIOD = 50000,
    parameter int TIMEOUT        = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lcd_finish,
`ifdef LCD_SEQ_FORCE_REFRESH_EN
    input  logic       force_ref,
`endif
    output logic       lcd_enable,
    output logic       mode,
    output logic [1:0] lcd_cnt,
    output logic       busy,
    output logic       init_done,
    output logic       err
);

    localparam int TMR_W = $clog2(REFRESH_PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [1:0]       LAST_STEP  = 2'(INIT_STEPS - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_PERIOD - 1);
    // Count value in the final permitted wait cycle; a finish there still wins.
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT_ISSUE,
        INIT_WAIT,
        REF_TMR,
        REF_ISSUE,
        REF_WAIT,
        FAULT
    } state_t;

    state_t           state;
    logic [1:0]       step;
    logic [1:0]       row;
    logic [TMR_W-1:0] timer;
    logic [TMO_W-1:0] tmo;
    logic             force_hit;

`ifdef LCD_SEQ_FORCE_REFRESH_EN
    assign force_hit = force_ref;
`else
    assign force_hit = 1'b0;
`endif

    // Outputs are computed together with the next state so that they are
    // valid in the same cycle the new state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step       <= '0;
            row        <= '0;
            timer      <= '0;
            tmo        <= '0;
            lcd_enable <= 1'b0;
            mode       <= 1'b0;
            lcd_cnt    <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            lcd_enable <= 1'b0;
            case (state)
                IDLE, FAULT: begin
                    if (start) begin
                        state      <= INIT_ISSUE;
                        step       <= '0;
                        init_done  <= 1'b0;
                        err        <= 1'b0;
                        lcd_enable <= 1'b1;
                        mode       <= 1'b0;
                        lcd_cnt    <= '0;
                        busy       <= 1'b1;
                    end
                end
                INIT_ISSUE: begin
                    state <= INIT_WAIT;
                    tmo   <= '0;
                end
                INIT_WAIT: begin
                    if (lcd_finish) begin
                        tmo <= '0;
                        if (step == LAST_STEP) begin
                            init_done <= 1'b1;
                            timer     <= TMR_RELOAD;
                            busy      <= 1'b0;
                            state     <= REF_TMR;
                        end else begin
                            step       <= step + 2'd1;
                            lcd_enable <= 1'b1;
                            mode       <= 1'b0;
                            lcd_cnt    <= step + 2'd1;
                            state      <= INIT_ISSUE;
                        end
                    end else if (tmo == TMO_LAST) begin
                        state <= FAULT;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                REF_TMR: begin
                    // Timer reads REFRESH_PERIOD-1 .. 0, then the strobe
                    // follows in the next cycle.
                    if (timer == '0 || force_hit) begin
                        lcd_enable <= 1'b1;
                        mode       <= 1'b1;
                        lcd_cnt    <= row;
                        busy       <= 1'b1;
                        state      <= REF_ISSUE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                REF_ISSUE: begin
                    state <= REF_WAIT;
                    tmo   <= '0;
                end
                REF_WAIT: begin
                    if (lcd_finish) begin
                        tmo   <= '0;
                        row   <= row + 2'd1;
                        timer <= TMR_RELOAD;
                        busy  <= 1'b0;
                        state <= REF_TMR;
                    end else if (tmo == TMO_LAST) begin
                        state <= FAULT;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl (INIT_STEPS=4, REFRESH_PERIOD=8,
// TIMEOUT=16). The bench plays the engine: on every strobe it checks the
// expected command (from a step/row model), answers after a random delay,
// withholds the answer, or resets mid-command, and checks strobe spacing.
module tb_lcd_seq_ctrl;

    localparam int INIT_STEPS     = 4;
    localparam int REFRESH_PERIOD = 8;
    localparam int TIMEOUT        = 16;

    logic       clk = 1'b0;
    logic       rst, start, lcd_finish;
    logic       lcd_enable, mode, busy, init_done, err;
    logic [1:0] lcd_cnt;
`ifdef LCD_SEQ_FORCE_REFRESH_EN
    logic       force_ref;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: where the sequence is, in plain terms.
    bit in_ref;
    int stepi, row;
    bit idone;
    int force_k = -1;  // force refresh at this REF_TMR cycle index (-1: none)

    always #5 clk = ~clk;

    lcd_seq_ctrl #(
        .INIT_STEPS    (INIT_STEPS),
        .REFRESH_PERIOD(REFRESH_PERIOD),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lcd_finish(lcd_finish),
`ifdef LCD_SEQ_FORCE_REFRESH_EN
        .force_ref (force_ref),
`endif
        .lcd_enable(lcd_enable),
        .mode      (mode),
        .lcd_cnt   (lcd_cnt),
        .busy      (busy),
        .init_done (init_done),
        .err       (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_force(input bit v);
`ifdef LCD_SEQ_FORCE_REFRESH_EN
        force_ref = v;
`else
        if (v) $display("note: force_ref not built");
`endif
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},    int'(lcd_enable), 0);
        chk({tag, "_mode"},  int'(mode),       0);
        chk({tag, "_cnt"},   int'(lcd_cnt),    0);
        chk({tag, "_busy"},  int'(busy),       0);
        chk({tag, "_idone"}, int'(init_done),  0);
        chk({tag, "_err"},   int'(err),        0);
    endtask

    // Start pulse in this cycle; the init strobe must appear next cycle.
    task automatic do_start();
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        chk("start_en",    int'(lcd_enable), 1);
        chk("start_mode",  int'(mode),       0);
        chk("start_cnt",   int'(lcd_cnt),    0);
        chk("start_busy",  int'(busy),       1);
        chk("start_idone", int'(init_done),  0);
        chk("start_err",   int'(err),        0);
        in_ref = 1'b0;
        stepi  = 0;
        idone  = 1'b0;
    endtask

    // From the cycle after a finish, expect the next strobe after g quiet
    // cycles. Start/finish noise in refresh gaps must be ignored.
    task automatic expect_gap(input int g, input int hm, input int hc);
        for (int k = 0; k < g; k++) begin
            chk("gap_en",   int'(lcd_enable), 0);
            chk("gap_busy", int'(busy),       0);
            chk("gap_mode", int'(mode),       hm);
            chk("gap_cnt",  int'(lcd_cnt),    hc);
            if (k == force_k) begin
                set_force(1'b1);
                step_cyc();
                set_force(1'b0);
                force_k = -1;
                chk("force_en", int'(lcd_enable), 1);
                return;
            end
            start      = 1'($urandom_range(0, 1));
            lcd_finish = 1'($urandom_range(0, 1));
            step_cyc();
            start      = 1'b0;
            lcd_finish = 1'b0;
        end
        chk("strobe_en", int'(lcd_enable), 1);
    endtask

    // Called in a strobe cycle. kind 0: finish in wait cycle d;
    // kind 1: never finish (timeout); kind 2: reset in wait cycle d.
    task automatic cmd(input int kind, input int d, input bit frc_wait);
        int ecnt;
        ecnt = in_ref ? row : stepi;
        chk("cmd_mode", int'(mode),    int'(in_ref));
        chk("cmd_cnt",  int'(lcd_cnt), ecnt);
        chk("cmd_busy", int'(busy),    1);
        if (kind == 0) begin
            for (int k = 1; k <= d; k++) begin
                set_force(frc_wait);
                step_cyc();
                chk("wait_en",   int'(lcd_enable), 0);
                chk("wait_busy", int'(busy),       1);
                if (k == d) lcd_finish = 1'b1;
            end
            set_force(1'b0);
            step_cyc();
            lcd_finish = 1'b0;
            if (!in_ref) begin
                if (stepi == INIT_STEPS - 1) begin
                    idone  = 1'b1;
                    in_ref = 1'b1;
                    chk("idone", int'(init_done), 1);
                    expect_gap(REFRESH_PERIOD, 0, ecnt);
                end else begin
                    stepi++;
                    chk("idone", int'(init_done), 0);
                    expect_gap(0, 0, ecnt);
                end
            end else begin
                row = (row + 1) % 4;
                chk("idone", int'(init_done), 1);
                expect_gap(REFRESH_PERIOD, 1, ecnt);
            end
        end else if (kind == 1) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                step_cyc();
                chk("tmo_en",   int'(lcd_enable), 0);
                chk("tmo_busy", int'(busy),       1);
                chk("tmo_err",  int'(err),        0);
            end
            step_cyc();
            chk("fault_err",   int'(err),        1);
            chk("fault_busy",  int'(busy),       0);
            chk("fault_en",    int'(lcd_enable), 0);
            chk("fault_idone", int'(init_done),  int'(idone));
            for (int k = 0; k < 3; k++) begin
                lcd_finish = 1'($urandom_range(0, 1));
                step_cyc();
                lcd_finish = 1'b0;
                chk("fault_hold_en",  int'(lcd_enable), 0);
                chk("fault_hold_err", int'(err),        1);
            end
            do_start();
        end else begin
            for (int k = 1; k <= d; k++) step_cyc();
            rst = 1'b1;
            step_cyc();
            rst = 1'b0;
            chk_reset_vals("midrst");
            row = 0;
            lcd_finish = 1'b1;
            step_cyc();
            lcd_finish = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk("stray_en",   int'(lcd_enable), 0);
                chk("stray_busy", int'(busy),       0);
                step_cyc();
            end
            do_start();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst        = 1'b1;
        start      = 1'b0;
        lcd_finish = 1'b0;
        set_force(1'b0);
        in_ref = 1'b0;
        stepi  = 0;
        row    = 0;
        idone  = 1'b0;
        step_cyc();
        step_cyc();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Reset abandons the step-2 init command.
        do_start();
        cmd(0, 3, 1'b0);
        cmd(0, 3, 1'b0);
        cmd(2, 2, 1'b0);

        // Full init then five refreshes with row wrap; one at the timeout edge.
        for (int i = 0; i < INIT_STEPS; i++) cmd(0, 3, 1'b0);
        for (int i = 0; i < 5; i++) cmd(0, (i == 2) ? TIMEOUT : 3, 1'b0);
        // Timeout during refresh, then restart.
        cmd(1, 0, 1'b0);
        cmd(0, TIMEOUT, 1'b0);

`ifdef LCD_SEQ_FORCE_REFRESH_EN
        // force_ref held through an init wait has no effect; then force
        // a refresh two cycles into the refresh timer.
        cmd(0, 5, 1'b1);
        for (int i = 0; i < 2; i++) cmd(0, 3, 1'b0);
        force_k = 1;
        cmd(0, 3, 1'b0);
        cmd(0, 3, 1'b0);
`endif

        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       cmd(1, 0, 1'b0);
            else if (r < 14) cmd(2, $urandom_range(1, TIMEOUT - 1), 1'b0);
            else             cmd(0, $urandom_range(1, TIMEOUT), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
